// File: rtl/tl_pkg.sv
// TileLink D-channel opcode constants and arbiter state encoding shared by the crossbar arbiters.
package tl_pkg;

   typedef enum logic [2:0] {
      ACCESS_ACK      = 3'd0,
      ACCESS_ACK_DATA = 3'd1,
      HINT_ACK        = 3'd2,
      GRANT           = 3'd4,
      GRANT_DATA      = 3'd5,
      RELEASE_ACK     = 3'd6
   } tl_d_op_e;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   function automatic logic tl_has_data(input logic [2:0] opcode);
      return (opcode == 3'(ACCESS_ACK_DATA)) || (opcode == 3'(GRANT_DATA));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set request at or above ptr_i, wrapping; purely combinational.
module rr_arbiter #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   int          k;
   logic [IW-1:0] kk;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      k     = 0;
      kk    = '0;
      // Walk from the farthest offset down so the nearest request overwrites last.
      for (int i = N - 1; i >= 0; i--) begin
         k  = (int'(ptr_i) + i) % N;
         kk = IW'(k);
         if (req_i[kk]) begin
            vld_o = 1'b1;
            idx_o = kk;
         end
      end
      if (vld_o) gnt_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/tl_resp_arbiter_d.sv
// D-channel return arbiter: round-robin over slaves, burst-locked, one-cycle registered output slice.
module tl_resp_arbiter_d
   import tl_pkg::*;
#(
   parameter int  SLAVE_NUM  = 8,
   parameter int  DATA_BYTES = 8,
   parameter int  SIZE_WIDTH = 3,
   parameter int  MAX_SIZE   = 6,
   parameter type DATA_T     = logic [0:0]
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [SLAVE_NUM-1:0]                  inp_valid_i,
   output logic [SLAVE_NUM-1:0]                  inp_ready_o,
   input  logic [SLAVE_NUM-1:0][2:0]             inp_opcode_i,
   input  logic [SLAVE_NUM-1:0][SIZE_WIDTH-1:0]  inp_size_i,
   input  DATA_T [SLAVE_NUM-1:0]                 inp_data_i,
   output logic                                  oup_valid_o,
   input  logic                                  oup_ready_i,
   output DATA_T                                 oup_data_o,
   output logic [$clog2(SLAVE_NUM)-1:0]          oup_slave_o,
   input  logic [SLAVE_NUM-1:0]                  connectivity_map_i,
   output logic                                  locked_o
);

   localparam int SW     = $clog2(SLAVE_NUM);
   localparam int DB_LOG = $clog2(DATA_BYTES);
   localparam int CW     = $clog2((2 ** MAX_SIZE) / DATA_BYTES) + 1;

   lock_state_e   state_q, state_d;
   logic [SW-1:0] ptr_q, ptr_d;
   logic [SW-1:0] frozen_q, frozen_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          oup_valid_q, oup_valid_d;
   DATA_T         oup_data_q, oup_data_d;
   logic [SW-1:0] oup_slave_q, oup_slave_d;

   logic [SLAVE_NUM-1:0] arb_gnt;
   logic [SW-1:0]        arb_idx;
   logic                 arb_vld;
   logic                 can_acc;
   logic [SW-1:0]        sel_idx;
   logic [SW-1:0]        sel_nxt;
   logic                 sel_vld;
   logic                 hs;
   logic [CW-1:0]        beats;
   int                   sz;

   rr_arbiter #(.N(SLAVE_NUM), .IW(SW)) u_rr (
      .req_i (inp_valid_i & connectivity_map_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   // The lock follows the frozen slave's raw valid so a map change cannot break a burst.
   assign can_acc = !oup_valid_q || oup_ready_i;
   assign sel_idx = (state_q == LOCKED) ? frozen_q : arb_idx;
   assign sel_vld = (state_q == LOCKED) ? inp_valid_i[frozen_q] : arb_vld;
   assign sel_nxt = (sel_idx == SW'(SLAVE_NUM - 1)) ? '0 : sel_idx + 1'b1;
   assign hs      = sel_vld && can_acc && !rst_i;

   always_comb begin
      inp_ready_o = '0;
      if (!rst_i && can_acc) begin
         if (state_q == LOCKED) inp_ready_o[frozen_q] = 1'b1;
         else                   inp_ready_o = arb_gnt;
      end
   end

   always_comb begin
      beats = CW'(1);
      sz    = int'(inp_size_i[arb_idx]);
      if (sz > MAX_SIZE) sz = MAX_SIZE;
      if (tl_has_data(inp_opcode_i[arb_idx]) && (sz > DB_LOG)) beats = CW'(1) << (sz - DB_LOG);
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      frozen_d    = frozen_q;
      cnt_d       = cnt_q;
      oup_valid_d = oup_valid_q;
      oup_data_d  = oup_data_q;
      oup_slave_d = oup_slave_q;

      if (hs) begin
         oup_valid_d = 1'b1;
         oup_data_d  = inp_data_i[sel_idx];
         oup_slave_d = sel_idx;
      end else if (oup_ready_i) begin
         oup_valid_d = 1'b0;
      end

      case (state_q)
         UNLOCKED: begin
            if (hs) begin
               if (beats > CW'(1)) begin
                  state_d  = LOCKED;
                  cnt_d    = beats - CW'(1);
                  frozen_d = arb_idx;
               end else begin
                  ptr_d = sel_nxt;
               end
            end
         end
         LOCKED: begin
            if (hs) begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = UNLOCKED;
                  ptr_d   = sel_nxt;
               end
            end
         end
         default: state_d = UNLOCKED;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= UNLOCKED;
         ptr_q       <= '0;
         frozen_q    <= '0;
         cnt_q       <= '0;
         oup_valid_q <= 1'b0;
         oup_data_q  <= '0;
         oup_slave_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         frozen_q    <= frozen_d;
         cnt_q       <= cnt_d;
         oup_valid_q <= oup_valid_d;
         oup_data_q  <= oup_data_d;
         oup_slave_q <= oup_slave_d;
      end
   end

   assign oup_valid_o = oup_valid_q;
   assign oup_data_o  = oup_data_q;
   assign oup_slave_o = oup_slave_q;
   assign locked_o    = (state_q == LOCKED);

endmodule

// File: doc/tl_resp_arbiter_d.md
Name: tl_resp_arbiter_D

Overview:
- Return-path counterpart of the crossbar A-channel address router: collects TileLink D-channel responses from SLAVE_NUM slave ports and delivers them to one master port.
- Round-robin arbitration among connected slaves; grant locked for all beats of a multi-beat data response.
- Output passes through a one-entry registered slice, so latency is one cycle.
- One instance per master port in tl_xbar.

Parameters:
SLAVE_NUM, 8, number of slave-side D inputs (>=2)
DATA_BYTES, 8, bytes per D beat (power of 2)
SIZE_WIDTH, 3, width of the D size field (log2 bytes)
MAX_SIZE, 6, largest legal transfer, log2 bytes; larger sizes are clamped to this
DATA_T, logic[0:0], full D-channel payload type, forwarded unmodified

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
inp_valid_i  input  [SLAVE_NUM]  per-slave D valid
inp_ready_o  output  [SLAVE_NUM]  per-slave D ready
inp_opcode_i  input  [SLAVE_NUM][3]  per-slave D opcode
inp_size_i  input  [SLAVE_NUM][SIZE_WIDTH]  per-slave D size
inp_data_i  input  [SLAVE_NUM] DATA_T  per-slave D payload
oup_valid_o  output  1  D valid to master
oup_ready_i  input  1  D ready from master
oup_data_o  output  DATA_T  registered payload
oup_slave_o  output  $clog2(SLAVE_NUM)  index of the slave that sourced the current output beat
connectivity_map_i  input  [SLAVE_NUM]  1 = slave may respond to this master
locked_o  output  1  burst lock held (for debug/assertions)

Behaviour:
- Interface: one clock, clk_i. rst_i is a synchronous, active-high reset.
- Reset values:
  - oup_valid_o=0, oup_data_o='0, oup_slave_o=0, locked_o=0.
  - Round-robin pointer = 0, beat counter = 0.
  - inp_ready_o=0 while rst_i=1.
- Eligibility: req = inp_valid_i & connectivity_map_i. A disconnected slave is never granted and its ready stays 0.
- Slice accept condition: can_acc = !oup_valid_o || oup_ready_i. Full throughput, one beat per cycle.
- State UNLOCKED, grant selection:
  - Pick the first set req bit at or above the pointer, wrapping modulo SLAVE_NUM.
  - inp_ready_o = one-hot(grant) & {can_acc}. All other readies are 0.
- Beat count:
  - Data opcodes are AccessAckData (1) and GrantData (5).
  - For a data opcode, beats = max(1, 2^min(size, MAX_SIZE) / DATA_BYTES). Otherwise beats = 1.
  - Beat counter width is $clog2(2^MAX_SIZE/DATA_BYTES)+1.
- Handshake in UNLOCKED (valid & ready on the granted slave):
  - Payload and slave index load into the output register.
  - If beats>1: go to LOCKED, counter = beats-1, grant frozen.
  - If beats==1: pointer = grant+1 (wrapping), stay UNLOCKED.
- State LOCKED:
  - Only the frozen slave can see ready, still gated by can_acc.
  - Opcode and size on later beats are ignored.
  - Each accepted beat decrements the counter.
  - When the beat with counter==1 is accepted: pointer = frozen+1, return to UNLOCKED, and arbitrate again in the next cycle.
  - A frozen slave that drops valid mid-burst stalls the output. No other slave is granted.
- Output slice:
  - Loads on every input handshake.
  - Clears oup_valid_o when oup_ready_i=1 and there is no new handshake.
  - oup_data_o and oup_slave_o are stable while oup_valid_o=1 and oup_ready_i=0.
- Simultaneous events:
  - Output drain and new load in the same cycle are allowed, giving back-to-back beats.
  - A connectivity_map_i change during LOCKED does not break the lock.
- Reset mid-burst: the lock is dropped, any held beat is discarded, and the pointer returns to 0. Slaves re-send per protocol.
- No combinational path from inp_valid_i or inp_data_i to the oup_* outputs. inp_ready_o depends combinationally on oup_ready_i.

Decomposition:
- tl_pkg holds the D opcode constants (ACCESS_ACK, ACCESS_ACK_DATA, GRANT_DATA, ...) and a function tl_has_data(opcode).
- A rr_arbiter sub-module (req, ptr -> one-hot grant plus index) is natural and reusable by the A-channel arbiter.
- Beat counter and output slice stay in this module.

Test Plan:
1. Slaves 2 and 5 each present an AccessAck (op 0), pointer 0, oup_ready_i=1:
   - Slave 2 appears on the output 1 cycle after its handshake, slave 5 the cycle after that.
   - oup_slave_o = 2 then 5; pointer ends at 6.
2. Slave 1 sends AccessAckData with size=6 (8 beats) while slave 3 is valid with a single-beat response throughout:
   - Slave 1 gets 8 consecutive grants and locked_o=1 for 7 cycles.
   - Slave 3 is granted on the 9th cycle.
3. Same as case 2 with oup_ready_i=0 for 3 cycles mid-burst:
   - oup_data_o is held, all inp_ready_o=0, no beat is lost, beat order is preserved.
4. connectivity_map_i=8'b1111_1011, only slave 2 valid:
   - oup_valid_o never rises and inp_ready_o[2]=0.
5. rst_i=1 in cycle 4 of an 8-beat burst:
   - Next cycle: oup_valid_o=0, locked_o=0, pointer 0.
   - A fresh single-beat response from slave 0 completes normally.
6. AccessAckData with size=2 (4B < DATA_BYTES):
   - Treated as 1 beat, no lock; the next slave is granted the following cycle.
